// File: rtl/uart_butterfly_loader_if.sv
// rtl/uart_butterfly_loader_if.sv - serial input and operand-set outputs of the butterfly loader
interface uart_butterfly_loader_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_RX_bit;
  logic [7:0]           o_RX_byte;
  logic                 o_RX_done;
  logic                 o_framing_error;
  logic [WORD_SIZE-1:0] o_in0_re;
  logic [WORD_SIZE-1:0] o_in0_im;
  logic [WORD_SIZE-1:0] o_in1_re;
  logic [WORD_SIZE-1:0] o_in1_im;
  logic [WORD_SIZE-1:0] o_twiddle_re;
  logic [WORD_SIZE-1:0] o_twiddle_im;
  logic                 o_frame_valid;
  logic [3:0]           o_byte_index;

  modport slave (
    input  i_RX_bit,
    output o_RX_byte, o_RX_done, o_framing_error,
    output o_in0_re, o_in0_im, o_in1_re, o_in1_im, o_twiddle_re, o_twiddle_im,
    output o_frame_valid, o_byte_index
  );

  modport master (
    output i_RX_bit,
    input  o_RX_byte, o_RX_done, o_framing_error,
    input  o_in0_re, o_in0_im, o_in1_re, o_in1_im, o_twiddle_re, o_twiddle_im,
    input  o_frame_valid, o_byte_index
  );
endinterface

// File: rtl/uart_butterfly_loader.sv
// rtl/uart_butterfly_loader.sv - 8N1 UART receiver packing 12 bytes into a butterfly operand set
// Optional partial-frame idle timeout enabled by defining UART_LOADER_TIMEOUT_EN.
module uart_butterfly_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int WORD_SIZE    = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  uart_butterfly_loader_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          meta_q, sync_q;
  logic          start_det;

  logic [3:0]                 idx_q, idx_d;
  logic [5:0][WORD_SIZE-1:0]  sh_q, sh_d;
  logic [5:0][WORD_SIZE-1:0]  out_q, out_d;
  logic                       fv_q, fv_d;
  logic                       tmo_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= bus.i_RX_bit;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Samples land mid-bit: START waits half a bit, then DATA/STOP step a full bit each.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    start_det = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sync_q) begin
          cnt_d     = '0;
          state_d   = START;
          start_det = 1'b1;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (sync_q) begin
            byte_d  = shift_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if (state_q == IDLE && idx_q != 4'd0 && !start_det) begin
      if (tmo_q == TMO_LAST) tmo_hit = 1'b1;
      else                   tmo_d   = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // The 12th byte is merged into the shadow copy on its way to the outputs,
  // so the whole set updates one cycle after its o_RX_done.
  always_comb begin
    sh_d  = sh_q;
    out_d = out_q;
    idx_d = idx_q;
    fv_d  = 1'b0;
    if (done_q) begin
      if (idx_q[0]) sh_d[idx_q[3:1]][15:8] = byte_q;
      else          sh_d[idx_q[3:1]][7:0]  = byte_q;
      if (idx_q == 4'd11) begin
        out_d = sh_d;
        fv_d  = 1'b1;
        idx_d = 4'd0;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end else if (tmo_hit) begin
      idx_d = 4'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_q <= '0;
      sh_q  <= '0;
      out_q <= '0;
      fv_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      sh_q  <= sh_d;
      out_q <= out_d;
      fv_q  <= fv_d;
    end
  end

  assign bus.o_RX_byte       = byte_q;
  assign bus.o_RX_done       = done_q;
  assign bus.o_framing_error = ferr_q;
  assign bus.o_in0_re        = out_q[0];
  assign bus.o_in0_im        = out_q[1];
  assign bus.o_in1_re        = out_q[2];
  assign bus.o_in1_im        = out_q[3];
  assign bus.o_twiddle_re    = out_q[4];
  assign bus.o_twiddle_im    = out_q[5];
  assign bus.o_frame_valid   = fv_q;
  assign bus.o_byte_index    = idx_q;

endmodule

// File: tb/tb_uart_butterfly_loader.sv
// tb/tb_uart_butterfly_loader.sv - directed self-checking bench for uart_butterfly_loader
module tb_uart_butterfly_loader;

  localparam int CPB = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   n_done;
  int   n_fv;
  int   n_ferr;
  int   n_overlap;
  int   done_cyc;
  int   fv_cyc;

  uart_butterfly_loader_if #(.WORD_SIZE(16)) bus ();

  uart_butterfly_loader #(
    .CLKS_PER_BIT(CPB),
    .WORD_SIZE   (16),
    .TIMEOUT_BITS(20)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_RX_done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (bus.o_frame_valid) begin
      n_fv   <= n_fv + 1;
      fv_cyc <= cyc;
    end
    if (bus.o_framing_error) n_ferr <= n_ferr + 1;
    if (bus.o_RX_done && bus.o_frame_valid) n_overlap <= n_overlap + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.i_RX_bit = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.i_RX_bit = b[i];
      repeat (CPB) @(posedge clk);
    end
    bus.i_RX_bit = stop_bit;
    repeat (CPB) @(posedge clk);
    bus.i_RX_bit = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.o_byte_index !== 4'd0) begin
      errors++; $display("FAIL reset_index: got %0d expected 0", bus.o_byte_index);
    end
    checks++;
    if ({bus.o_RX_byte, bus.o_RX_done, bus.o_framing_error, bus.o_frame_valid} !== 11'd0) begin
      errors++; $display("FAIL reset_rx: byte %h done %b ferr %b fv %b expected all 0",
                         bus.o_RX_byte, bus.o_RX_done, bus.o_framing_error, bus.o_frame_valid);
    end
    checks++;
    if ({bus.o_in0_re, bus.o_in0_im, bus.o_in1_re, bus.o_in1_im, bus.o_twiddle_re, bus.o_twiddle_im} !== 96'd0) begin
      errors++; $display("FAIL reset_words: in0_re %h twiddle_im %h expected 0", bus.o_in0_re, bus.o_twiddle_im);
    end
  endtask

  task automatic test_single_byte();
    int d0 = n_done;
    int f0 = n_ferr;
    send_byte(8'hA5, 1'b1);
    checks++;
    if (n_done - d0 !== 1) begin
      errors++; $display("FAIL single_done_count: got %0d expected 1", n_done - d0);
    end
    checks++;
    if (bus.o_RX_byte !== 8'hA5) begin
      errors++; $display("FAIL single_byte: got %h expected a5", bus.o_RX_byte);
    end
    checks++;
    if (bus.o_byte_index !== 4'd1) begin
      errors++; $display("FAIL single_index: got %0d expected 1", bus.o_byte_index);
    end
    checks++;
    if (n_ferr !== f0) begin
      errors++; $display("FAIL single_ferr: got %0d pulses expected 0", n_ferr - f0);
    end
  endtask

  task automatic test_frame();
    logic [7:0] v [12] = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h03,
                           8'h00, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00};
    int fv0;
    do_reset();
    fv0 = n_fv;
    for (int i = 0; i < 12; i++) send_byte(v[i], 1'b1);
    checks++;
    if (n_fv - fv0 !== 1) begin
      errors++; $display("FAIL frame_fv_count: got %0d expected 1", n_fv - fv0);
    end
    checks++;
    if (fv_cyc !== done_cyc + 1) begin
      errors++; $display("FAIL frame_latency: fv at %0d expected %0d", fv_cyc, done_cyc + 1);
    end
    checks++;
    if ({bus.o_in0_re, bus.o_in0_im, bus.o_in1_re} !== {16'h0200, 16'h0100, 16'h0300}) begin
      errors++; $display("FAIL frame_in: in0_re %h in0_im %h in1_re %h expected 0200 0100 0300",
                         bus.o_in0_re, bus.o_in0_im, bus.o_in1_re);
    end
    checks++;
    if ({bus.o_in1_im, bus.o_twiddle_re, bus.o_twiddle_im} !== {16'hFF00, 16'h0100, 16'h0000}) begin
      errors++; $display("FAIL frame_tw: in1_im %h tw_re %h tw_im %h expected ff00 0100 0000",
                         bus.o_in1_im, bus.o_twiddle_re, bus.o_twiddle_im);
    end
    checks++;
    if (bus.o_byte_index !== 4'd0) begin
      errors++; $display("FAIL frame_index: got %0d expected 0", bus.o_byte_index);
    end
    checks++;
    if (n_overlap !== 0) begin
      errors++; $display("FAIL done_fv_overlap: got %0d expected 0", n_overlap);
    end
  endtask

  task automatic test_glitch();
    int d0 = n_done;
    @(negedge clk);
    bus.i_RX_bit = 1'b0;
    repeat (5) @(negedge clk);
    bus.i_RX_bit = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checks++;
    if (n_done !== d0) begin
      errors++; $display("FAIL glitch_done: got %0d pulses expected 0", n_done - d0);
    end
    checks++;
    if (bus.o_byte_index !== 4'd0) begin
      errors++; $display("FAIL glitch_index: got %0d expected 0", bus.o_byte_index);
    end
    send_byte(8'h5A, 1'b1);
    checks++;
    if (bus.o_RX_byte !== 8'h5A || bus.o_byte_index !== 4'd1) begin
      errors++; $display("FAIL glitch_recover: byte %h index %0d expected 5a 1", bus.o_RX_byte, bus.o_byte_index);
    end
  endtask

  task automatic test_framing_error();
    int f0 = n_ferr;
    int d0 = n_done;
    send_byte(8'h3C, 1'b0);
    checks++;
    if (n_ferr - f0 !== 1 || n_done !== d0) begin
      errors++; $display("FAIL ferr_pulse: ferr %0d done %0d expected 1 0", n_ferr - f0, n_done - d0);
    end
    checks++;
    if (bus.o_RX_byte !== 8'h5A || bus.o_byte_index !== 4'd1) begin
      errors++; $display("FAIL ferr_hold: byte %h index %0d expected 5a 1", bus.o_RX_byte, bus.o_byte_index);
    end
    send_byte(8'h77, 1'b1);
    for (int i = 0; i < 10; i++) send_byte(8'h10 + 8'(i), 1'b1);
    checks++;
    if (bus.o_in0_re !== 16'h775A || bus.o_in0_im !== 16'h1110) begin
      errors++; $display("FAIL ferr_resume: in0_re %h in0_im %h expected 775a 1110", bus.o_in0_re, bus.o_in0_im);
    end
  endtask

  task automatic test_reset_mid_frame();
    int fv0;
    for (int i = 0; i < 5; i++) send_byte(8'hEE, 1'b1);
    do_reset();
    checks++;
    if (bus.o_in0_re !== 16'h0000 || bus.o_byte_index !== 4'd0) begin
      errors++; $display("FAIL midreset_clear: in0_re %h index %0d expected 0000 0", bus.o_in0_re, bus.o_byte_index);
    end
    fv0 = n_fv;
    for (int i = 0; i < 11; i++) send_byte(8'hB0 + 8'(i), 1'b1);
    checks++;
    if (n_fv !== fv0) begin
      errors++; $display("FAIL midreset_early_fv: got %0d expected 0", n_fv - fv0);
    end
    send_byte(8'hBB, 1'b1);
    checks++;
    if (n_fv - fv0 !== 1) begin
      errors++; $display("FAIL midreset_fv: got %0d expected 1", n_fv - fv0);
    end
    checks++;
    if ({bus.o_in0_re, bus.o_in1_im, bus.o_twiddle_im} !== {16'hB1B0, 16'hB7B6, 16'hBBBA}) begin
      errors++; $display("FAIL midreset_words: in0_re %h in1_im %h tw_im %h expected b1b0 b7b6 bbba",
                         bus.o_in0_re, bus.o_in1_im, bus.o_twiddle_im);
    end
  endtask

  task automatic test_timeout();
    int fv0;
    do_reset();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    repeat (21 * CPB) @(negedge clk);
    fv0 = n_fv;
`ifdef UART_LOADER_TIMEOUT_EN
    checks++;
    if (bus.o_byte_index !== 4'd0) begin
      errors++; $display("FAIL timeout_index: got %0d expected 0", bus.o_byte_index);
    end
    for (int i = 0; i < 12; i++) send_byte(8'h01 + 8'(i), 1'b1);
    checks++;
    if (n_fv - fv0 !== 1) begin
      errors++; $display("FAIL timeout_fv: got %0d expected 1", n_fv - fv0);
    end
    checks++;
    if ({bus.o_in0_re, bus.o_in0_im, bus.o_twiddle_im} !== {16'h0201, 16'h0403, 16'h0C0B}) begin
      errors++; $display("FAIL timeout_words: in0_re %h in0_im %h tw_im %h expected 0201 0403 0c0b",
                         bus.o_in0_re, bus.o_in0_im, bus.o_twiddle_im);
    end
`else
    checks++;
    if (bus.o_byte_index !== 4'd3) begin
      errors++; $display("FAIL notimeout_index: got %0d expected 3", bus.o_byte_index);
    end
    for (int i = 0; i < 9; i++) send_byte(8'h01 + 8'(i), 1'b1);
    checks++;
    if (n_fv - fv0 !== 1) begin
      errors++; $display("FAIL notimeout_fv: got %0d expected 1", n_fv - fv0);
    end
    checks++;
    if ({bus.o_in0_re, bus.o_in0_im, bus.o_in1_re, bus.o_twiddle_im} !== {16'h2211, 16'h0133, 16'h0302, 16'h0908}) begin
      errors++; $display("FAIL notimeout_words: in0_re %h in0_im %h in1_re %h tw_im %h expected 2211 0133 0302 0908",
                         bus.o_in0_re, bus.o_in0_im, bus.o_in1_re, bus.o_twiddle_im);
    end
    for (int i = 9; i < 12; i++) send_byte(8'h01 + 8'(i), 1'b1);
    checks++;
    if (bus.o_byte_index !== 4'd3 || n_fv - fv0 !== 1) begin
      errors++; $display("FAIL notimeout_tail: index %0d fv %0d expected 3 1", bus.o_byte_index, n_fv - fv0);
    end
`endif
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    n_done       = 0;
    n_fv         = 0;
    n_ferr       = 0;
    n_overlap    = 0;
    done_cyc     = 0;
    fv_cyc       = 0;
    rst_n        = 1'b1;
    bus.i_RX_bit = 1'b1;
    test_reset();
    test_single_byte();
    test_frame();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
